// File: rtl/intt_writeback_pkg.sv
// Shared widths, delay-line/group records and serializer state for the INTT writeback stage.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package intt_writeback_pkg;

    localparam int COEFF_W = 30;
    localparam int WORD_W  = 2 * COEFF_W;
    localparam int ADDR_W  = 9;
    localparam int GROUP_W = 4 * COEFF_W + 1;

    // One final-stage group as stored in the FIFO: {last, r4, r3, r2, r1}.
    typedef struct packed {
        logic               last;
        logic [COEFF_W-1:0] r4;
        logic [COEFF_W-1:0] r3;
        logic [COEFF_W-1:0] r2;
        logic [COEFF_W-1:0] r1;
    } group_t;

    // Issue-side information that has to travel alongside the core pipeline.
    typedef struct packed {
        logic              vld;
        logic              is_final;
        logic              last;
        logic [ADDR_W-1:0] upper_addr;
        logic [ADDR_W-1:0] lower_addr;
    } dl_stage_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } ser_state_t;

    // Coefficients leave a group in r1, r2, r3, r4 order.
    function automatic logic [COEFF_W-1:0] group_beat(input group_t g, input logic [1:0] beat);
        case (beat)
            2'd0:    return g.r1;
            2'd1:    return g.r2;
            2'd2:    return g.r3;
            default: return g.r4;
        endcase
    endfunction

endpackage

// File: rtl/intt_writeback_fifo.sv
// Generic synchronous FIFO with occupancy count; read data is the head entry (show-ahead).
// Latency: a push is visible at the head one cycle later.
// Backpressure: a push into a full FIFO is dropped and flagged, unless a pop frees a slot that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     push_drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign rdata_o     = mem_q[rd_ptr_q];
    assign do_pop      = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push     = push_i && (!full_o || do_pop);
    assign push_drop_o = push_i && !do_push;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks net push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/intt_writeback.sv
// Routes INTT core butterfly results: RAM writeback for inner stages, 4-beat coefficient stream for the final stage.
// Latency: RAM write at issue+PIPE_LATENCY+1; first stream beat at issue+PIPE_LATENCY+2 when idle.
// Backpressure: out_ready stalls the serializer; stall_req throttles the sequencer before the FIFO can overflow.
module intt_writeback
    import intt_writeback_pkg::*;
#(
    parameter int LOG_CORE_COUNT = 4,
    parameter int PIPE_LATENCY   = 7,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [ADDR_W-1:0]    in_upper_addr,
    input  logic [ADDR_W-1:0]    in_lower_addr,
    input  logic                 in_final,
    input  logic                 in_last,
    input  logic [COEFF_W-1:0]   r1,
    input  logic [COEFF_W-1:0]   r2,
    input  logic [COEFF_W-1:0]   r3,
    input  logic [COEFF_W-1:0]   r4,
    output logic                 upper_write_enable,
    output logic [ADDR_W-1:0]    upper_write_address,
    output logic [WORD_W-1:0]    upper_data_input,
    output logic                 lower_write_enable,
    output logic [ADDR_W-1:0]    lower_write_address,
    output logic [WORD_W-1:0]    lower_data_input,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COEFF_W-1:0]   out_data,
    output logic                 out_last,
    output logic                 stall_req,
    output logic                 done,
    output logic                 overflow_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // Enough headroom for every issue already inside the core pipeline to land safely.
    localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(FIFO_DEPTH - PIPE_LATENCY - 1);

    // RAM address width is fixed by the core count (32 words per core slice).
    if (LOG_CORE_COUNT + 5 != ADDR_W) begin : g_bad_addr_cfg
        $error("intt_writeback: LOG_CORE_COUNT does not match ADDR_W");
    end

    // ------------------------------------------------------------------
    // Delay line: issue info re-aligned with r1..r4 at the tail.
    // ------------------------------------------------------------------
    dl_stage_t dl_q [PIPE_LATENCY];
    dl_stage_t dl_in;
    dl_stage_t dl_tail;

    assign dl_in = '{vld:        in_valid,
                     is_final:   in_final,
                     last:       in_last,
                     upper_addr: in_upper_addr,
                     lower_addr: in_lower_addr};
    assign dl_tail = dl_q[PIPE_LATENCY-1];

    // Shift issue info one stage per cycle; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= dl_in;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Inner-stage RAM writeback.
    // ------------------------------------------------------------------
    logic wb_fire;
    assign wb_fire = dl_tail.vld && !dl_tail.is_final;

    // Register the write ports; strobes pulse once, address/data hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upper_write_enable  <= 1'b0;
            lower_write_enable  <= 1'b0;
            upper_write_address <= '0;
            lower_write_address <= '0;
            upper_data_input    <= '0;
            lower_data_input    <= '0;
        end else begin
            upper_write_enable <= wb_fire;
            lower_write_enable <= wb_fire;
            if (wb_fire) begin
                upper_write_address <= dl_tail.upper_addr;
                lower_write_address <= dl_tail.lower_addr;
                upper_data_input    <= {r2, r1};
                lower_data_input    <= {r4, r3};
            end
        end
    end

    // ------------------------------------------------------------------
    // Final-stage group buffer.
    // ------------------------------------------------------------------
    logic                fifo_push;
    logic                fifo_pop;
    group_t              fifo_wgroup;
    logic [GROUP_W-1:0]  fifo_rdata;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_drop;

    assign fifo_push   = dl_tail.vld && dl_tail.is_final;
    assign fifo_wgroup = '{last: dl_tail.last, r4: r4, r3: r3, r2: r2, r1: r1};

    sync_fifo #(
        .WIDTH (GROUP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_group_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .wdata_i     (fifo_wgroup),
        .pop_i       (fifo_pop),
        .rdata_o     (fifo_rdata),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .push_drop_o (fifo_drop)
    );

    assign stall_req = (fifo_count >= STALL_TH);

    // Sticky record of any group lost to a full buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (fifo_drop) begin
            overflow_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serializer: one coefficient per beat, gapless across groups.
    // ------------------------------------------------------------------
    ser_state_t state_q, state_d;
    logic [1:0] beat_q, beat_d;
    group_t     entry_q, entry_d;
    logic       done_q;

    // State register for the serializer and its held group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            entry_q <= entry_d;
        end
    end

    // Next-state: load a group when idle, advance on handshakes, reload at group end if more is waiting.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        entry_d  = entry_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    entry_d  = group_t'(fifo_rdata);
                    beat_d   = 2'd0;
                    state_d  = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (beat_q != 2'd3) begin
                        beat_d = beat_q + 2'd1;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        entry_d  = group_t'(fifo_rdata);
                        beat_d   = 2'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: beat data comes straight from the held group, so it is stable while stalled.
    always_comb begin
        out_valid = (state_q == S_EMIT);
        out_data  = group_beat(entry_q, beat_q);
        out_last  = out_valid && entry_q.last && (beat_q == 2'd3);
    end

    // Completion pulse one cycle after the closing beat is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= out_last && out_ready;
        end
    end

    assign done = done_q;

endmodule
